// File: rtl/mux_sel_scanner.sv
// Scans the enabled channels of a downstream 4:1 mux and settles on each one
// before sampling it. When a frame is complete it presents a 4-bit snapshot.
// Ports: clk, rst_n (async, active-low); start, mask[3:0], dwell[DWELL_W-1:0],
//        mux_out in; s0/s1 select, sample[3:0], frame_valid, busy, err out.
module mux_sel_scanner #(
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [3:0]         mask,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               mux_out,
    output logic               s0,
    output logic               s1,
    output logic [3:0]         sample,
    output logic               frame_valid,
    output logic               busy,
    output logic               err
);

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

    state_t             state, state_d;
    logic [3:0]         mask_q, mask_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [3:0]         acc_q, acc_d;
    logic [1:0]         sel_q, sel_d;
    logic [3:0]         sample_q, sample_d;
    logic               fv_q, fv_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;

    // Lowest enabled channel of m.
    function automatic logic [1:0] first_ch(input logic [3:0] m);
        first_ch = 2'd0;
        for (int i = 3; i >= 0; i--)
            if (m[i]) first_ch = 2'(i);
    endfunction

    // Any enabled channel strictly above c?
    function automatic logic has_next(input logic [3:0] m,
                                      input logic [1:0] c);
        has_next = 1'b0;
        for (int i = 0; i < 4; i++)
            if (m[i] && i > int'(c)) has_next = 1'b1;
    endfunction

    // Lowest enabled channel strictly above c.
    function automatic logic [1:0] next_ch(input logic [3:0] m,
                                           input logic [1:0] c);
        next_ch = c;
        for (int i = 3; i >= 0; i--)
            if (m[i] && i > int'(c)) next_ch = 2'(i);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d  = state;
        mask_d   = mask_q;
        dwell_d  = dwell_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        sel_d    = sel_q;
        sample_d = sample_q;
        busy_d   = busy_q;
        fv_d     = 1'b0;
        err_d    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (mask != 4'd0) begin
                        mask_d  = mask;
                        dwell_d = dwell;
                        acc_d   = 4'd0;
                        sel_d   = first_ch(mask);
                        cnt_d   = dwell;
                        busy_d  = 1'b1;
                        state_d = SETTLE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            SETTLE: begin
                if (cnt_q == '0) state_d = SAMPLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            SAMPLE: begin
                acc_d[sel_q] = mux_out;
                if (has_next(mask_q, sel_q)) begin
                    sel_d   = next_ch(mask_q, sel_q);
                    cnt_d   = dwell_q;
                    state_d = SETTLE;
                end else begin
                    // Snapshot is published on entry to DONE so that
                    // frame_valid and sample are both visible in DONE.
                    sample_d = acc_d & mask_q;
                    fv_d     = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                sel_d   = 2'd0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q   <= 4'd0;
            dwell_q  <= '0;
            cnt_q    <= '0;
            acc_q    <= 4'd0;
            sel_q    <= 2'd0;
            sample_q <= 4'd0;
            fv_q     <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            mask_q   <= mask_d;
            dwell_q  <= dwell_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            sel_q    <= sel_d;
            sample_q <= sample_d;
            fv_q     <= fv_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
        end
    end

    assign s0          = sel_q[0];
    assign s1          = sel_q[1];
    assign sample      = sample_q;
    assign frame_valid = fv_q;
    assign busy        = busy_q;
    assign err         = err_q;

endmodule

// File: tb/tb_mux_sel_scanner.sv
// Testbench for mux_sel_scanner: a 4:1 mux is modelled around the DUT and
// each scan is checked against select trace, latency and snapshot expectations.
module tb_mux_sel_scanner;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] mask;
    logic [3:0] dwell;
    logic       mux_out;
    logic       s0, s1;
    logic [3:0] sample;
    logic       frame_valid, busy, err;
    logic [3:0] ch_in;

    int n_cmp = 0;
    int n_bad = 0;
    logic [3:0] last_sample;

    always #5 clk = ~clk;

    assign mux_out = ch_in[{s1, s0}];

    mux_sel_scanner #(.DWELL_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mask(mask),
        .dwell(dwell), .mux_out(mux_out), .s0(s0), .s1(s1),
        .sample(sample), .frame_valid(frame_valid), .busy(busy), .err(err)
    );

    // Runs one scan from IDLE and checks trace, latency and snapshot.
    task automatic do_scan(input logic [3:0] m, input logic [3:0] d,
                           input logic [3:0] c, input string name);
        int chs[$];
        int n, exp_lat, lat, idx, sel_bad, busy_bad;
        logic [3:0] exp_s;
        chs = {};
        for (int i = 0; i < 4; i++) if (m[i]) chs.push_back(i);
        n = chs.size();
        exp_lat = 1 + n * (int'(d) + 2);
        exp_s = m & c;
        lat = -1; sel_bad = 0; busy_bad = 0;
        @(negedge clk);
        mask = m; dwell = d; ch_in = c; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 300; k++) begin
            if (k > 1) @(negedge clk);
            if (busy !== 1'b1) busy_bad++;
            if (frame_valid === 1'b1) begin lat = k; break; end
            idx = (k - 1) / (int'(d) + 2);
            if (idx < n && int'({s1, s0}) != chs[idx]) sel_bad++;
        end
        n_cmp++;
        if (lat != exp_lat) begin
            n_bad++;
            $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
        end
        n_cmp++;
        if (sel_bad != 0 || busy_bad != 0) begin
            n_bad++;
            $display("FAIL %s trace: sel errs %0d busy errs %0d want 0 0",
                     name, sel_bad, busy_bad);
        end
        n_cmp++;
        if (sample !== exp_s) begin
            n_bad++;
            $display("FAIL %s sample: got %b want %b", name, sample, exp_s);
        end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || frame_valid !== 1'b0 || {s1, s0} !== 2'b00 ||
            sample !== exp_s) begin
            n_bad++;
            $display("FAIL %s after: busy %b fv %b sel %b sample %b want 0 0 00 %b",
                     name, busy, frame_valid, {s1, s0}, sample, exp_s);
        end
        last_sample = exp_s;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; mask = 4'd0; dwell = 4'd0; ch_in = 4'd0;
        #3;
        n_cmp++;
        if ({s1, s0, sample, frame_valid, busy, err} !== 9'd0) begin
            n_bad++;
            $display("FAIL reset: got %b want 000000000",
                     {s1, s0, sample, frame_valid, busy, err});
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        last_sample = 4'd0;
    endtask

    task automatic test_full_scan();
        do_scan(4'b1111, 4'd2, 4'b1101, "full");
    endtask

    task automatic test_sparse();
        do_scan(4'b1010, 4'd0, 4'b1111, "sparse");
    endtask

    task automatic test_zero_mask();
        @(negedge clk);
        mask = 4'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if (err !== 1'b1 || busy !== 1'b0 || sample !== last_sample) begin
            n_bad++;
            $display("FAIL zero_mask pulse: err %b busy %b sample %b want 1 0 %b",
                     err, busy, sample, last_sample);
        end
        @(negedge clk);
        n_cmp++;
        if (err !== 1'b0 || busy !== 1'b0 || frame_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL zero_mask after: err %b busy %b fv %b want 0 0 0",
                     err, busy, frame_valid);
        end
    endtask

    task automatic test_mid_reset();
        int fv_seen;
        fv_seen = 0;
        @(negedge clk);
        mask = 4'b1111; dwell = 4'd5; ch_in = 4'b0110; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // cycles 1..6 settle ch0, 7 sample, 8.. settle ch1
        for (int k = 2; k <= 9; k++) @(negedge clk);
        n_cmp++;
        if ({s1, s0} !== 2'b01 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_reset pre: sel %b busy %b want 01 1",
                     {s1, s0}, busy);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({s1, s0, sample, frame_valid, busy, err} !== 9'd0) begin
            n_bad++;
            $display("FAIL mid_reset async: got %b want 000000000",
                     {s1, s0, sample, frame_valid, busy, err});
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (frame_valid !== 1'b0) fv_seen++;
        end
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (frame_valid !== 1'b0 || busy !== 1'b0) fv_seen++;
        end
        n_cmp++;
        if (fv_seen != 0) begin
            n_bad++;
            $display("FAIL mid_reset quiet: got %0d events want 0", fv_seen);
        end
        last_sample = 4'd0;
        do_scan(4'b1111, 4'd1, 4'b1001, "post_reset");
    endtask

    task automatic test_busy_ignore();
        int lat, extra;
        logic a;
        a = 1'($urandom_range(0, 1));
        lat = -1; extra = 0;
        @(negedge clk);
        mask = 4'b0001; dwell = 4'd15; ch_in = {3'b111, a}; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            if (k > 1) @(negedge clk);
            if (k == 5) begin mask = 4'b1111; dwell = 4'd3; start = 1'b1; end
            if (k == 6) start = 1'b0;
            if (frame_valid === 1'b1) begin lat = k; break; end
        end
        n_cmp++;
        if (lat != 18) begin
            n_bad++;
            $display("FAIL busy_ignore latency: got %0d want 18", lat);
        end
        n_cmp++;
        if (sample !== {3'b000, a}) begin
            n_bad++;
            $display("FAIL busy_ignore sample: got %b want %b",
                     sample, {3'b000, a});
        end
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (busy !== 1'b0 || frame_valid !== 1'b0) extra++;
        end
        n_cmp++;
        if (extra != 0) begin
            n_bad++;
            $display("FAIL busy_ignore idle: got %0d events want 0", extra);
        end
        last_sample = {3'b000, a};
    endtask

    task automatic test_back_to_back();
        int frames[$];
        logic expc[$];
        logic cval;
        int gap_bad, bit_bad;
        frames = {}; expc = {};
        gap_bad = 0; bit_bad = 0;
        cval = 1'($urandom_range(0, 1));
        @(negedge clk);
        mask = 4'b0100; dwell = 4'd1; ch_in = {1'b1, cval, 2'b11};
        start = 1'b1;
        for (int k = 1; k <= 40 && frames.size() < 5; k++) begin
            @(negedge clk);
            if (frame_valid === 1'b1) begin
                frames.push_back(k);
                if (sample !== {1'b0, cval, 2'b00}) bit_bad++;
                cval = 1'($urandom_range(0, 1));
                ch_in = {1'b1, cval, 2'b11};
            end
        end
        start = 1'b0;
        n_cmp++;
        if (frames.size() != 5 || frames[0] != 4) begin
            n_bad++;
            $display("FAIL b2b count: frames %0d first %0d want 5 4",
                     frames.size(), frames.size() > 0 ? frames[0] : -1);
        end
        for (int i = 1; i < frames.size(); i++)
            if (frames[i] - frames[i-1] != 5) gap_bad++;
        n_cmp++;
        if (gap_bad != 0) begin
            n_bad++;
            $display("FAIL b2b gap: got %0d bad gaps want 0", gap_bad);
        end
        n_cmp++;
        if (bit_bad != 0) begin
            n_bad++;
            $display("FAIL b2b sample: got %0d bad snapshots want 0", bit_bad);
        end
        for (int k = 0; k < 8; k++) @(negedge clk);
        last_sample = sample;
    endtask

    task automatic test_random();
        logic [3:0] m, d, c;
        for (int i = 0; i < 10; i++) begin
            m = 4'($urandom_range(1, 15));
            d = 4'($urandom_range(0, 4));
            c = 4'($urandom_range(0, 15));
            do_scan(m, d, c, $sformatf("rand%0d", i));
        end
    endtask

    initial begin
        test_reset();
        test_full_scan();
        test_sparse();
        test_zero_mask();
        test_mid_reset();
        test_busy_ignore();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
